// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the R-type issue sequencer.
//   OP_RTYPE      : R-type opcode
//   F7_* / F3_*   : funct7 / funct3 values of the supported operations
//   ALU_*         : 4-bit ALU encodings driven to the datapath (ALU_NOP = bubble)
//   state_t       : issue-stage FSM states
//   dec_op_t      : decoded instruction fields
package alu_issue_pkg;

  localparam logic [6:0] OP_RTYPE   = 7'b0110011;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [3:0] ALU_AND    = 4'b0000;
  localparam logic [3:0] ALU_OR     = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_XOR    = 4'b0011;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_SLT    = 4'b0111;
  localparam logic [3:0] ALU_NOP    = 4'b1111;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [3:0] alu_op;
    logic       legal;
  } dec_op_t;

endpackage

// File: rtl/alu_issue_ctrl_instr_fifo.sv
// Synchronous FIFO holding instruction words.
//   clock/reset : rising-edge clock, async active-low reset (clears pointers)
//   push/wdata  : write when push && !full
//   pop/rdata   : rdata is the head word; advance when pop && !empty
//   full/empty  : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguished
// without a separate counter. A push while full is refused even when a pop
// happens in the same cycle.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)  wptr <= wptr + 1'b1;
      if (pop  && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the register-file/ALU datapath.
//   instr_valid/instr/instr_ready : instruction input port (valid/ready)
//   run                           : issue enable; 0 holds issue, pipeline drains
//   alu_control/write_reg/regwrite: issue-stage controls (cycle t)
//   read_reg_num1/2               : read addresses (cycle t+1)
//   zero_flag                     : datapath zero, sampled at end of t+1
//   done_valid/done_rd/done_zero  : completion report (cycle t+2)
//   illegal                       : pulse in the issue cycle of a rejected word
//   retired_count                 : completed legal instructions, wraps
//   busy                          : FIFO non-empty or an instruction in flight
// Pipeline: pop (edge) -> issue stage -> read stage -> done stage.
// All datapath-facing outputs are registered, so they are 0 in reset and
// settle to bubble values (ALU_NOP) after the first clock.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  input  logic             run,
  output logic [4:0]       read_reg_num1,
  output logic [4:0]       read_reg_num2,
  output logic [4:0]       write_reg,
  output logic [3:0]       alu_control,
  output logic             regwrite,
  input  logic             zero_flag,
  output logic             done_valid,
  output logic [4:0]       done_rd,
  output logic             done_zero,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count,
  output logic             busy
);

  logic        fifo_full, fifo_empty, pop;
  logic [31:0] head;
  dec_op_t     dec;
  state_t      state, next_state;

  // issue-stage payload
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_legal;
  // read-stage payload
  logic [4:0]  rd_rd;
  logic        rd_legal;
  // [0] read stage occupied, [1] done stage occupied (legal only)
  logic [1:0]  vld_pipe;

  function automatic dec_op_t decode(input logic [31:0] w);
    dec_op_t d;
    d.rs1    = w[19:15];
    d.rs2    = w[24:20];
    d.rd     = w[11:7];
    d.alu_op = ALU_NOP;
    d.legal  = 1'b0;
    if (w[6:0] == OP_RTYPE) begin
      d.legal = 1'b1;
      case ({w[31:25], w[14:12]})
        {F7_BASE, F3_ADD_SUB}: d.alu_op = ALU_ADD;
        {F7_ALT,  F3_ADD_SUB}: d.alu_op = ALU_SUB;
        {F7_BASE, F3_AND}:     d.alu_op = ALU_AND;
        {F7_BASE, F3_OR}:      d.alu_op = ALU_OR;
        {F7_BASE, F3_XOR}:     d.alu_op = ALU_XOR;
        {F7_BASE, F3_SLT}:     d.alu_op = ALU_SLT;
        default:               d.legal  = 1'b0;
      endcase
    end
    return d;
  endfunction

  instr_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (instr_valid),
    .wdata (instr),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign instr_ready = !fifo_full;
  assign dec         = decode(head);
  assign busy        = !fifo_empty || (state == S_ISSUE) || vld_pipe[0];

  // ISSUE means the issue stage holds a popped word this cycle. A pop needs
  // only a non-empty FIFO and run, so issue stops the cycle run drops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = S_IDLE;
    pop        = 1'b0;
    if (run && !fifo_empty) begin
      next_state = S_ISSUE;
      pop        = 1'b1;
    end
  end

  // issue stage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alu_control <= '0;
      write_reg   <= '0;
      regwrite    <= 1'b0;
      illegal     <= 1'b0;
      iss_rs1     <= '0;
      iss_rs2     <= '0;
      iss_rd      <= '0;
      iss_legal   <= 1'b0;
    end else if (pop) begin
      alu_control <= dec.alu_op;
      write_reg   <= dec.legal ? dec.rd : 5'd0;
      regwrite    <= dec.legal && (dec.rd != 5'd0);
      illegal     <= !dec.legal;
      iss_rs1     <= dec.rs1;
      iss_rs2     <= dec.rs2;
      iss_rd      <= dec.rd;
      iss_legal   <= dec.legal;
    end else begin
      alu_control <= ALU_NOP;
      write_reg   <= '0;
      regwrite    <= 1'b0;
      illegal     <= 1'b0;
      iss_rs1     <= '0;
      iss_rs2     <= '0;
      iss_rd      <= '0;
      iss_legal   <= 1'b0;
    end
  end

  // read stage and done stage; zero_flag belongs to the read-stage instruction
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_reg_num1 <= '0;
      read_reg_num2 <= '0;
      rd_rd         <= '0;
      rd_legal      <= 1'b0;
      vld_pipe      <= '0;
      done_rd       <= '0;
      done_zero     <= 1'b0;
      retired_count <= '0;
    end else begin
      vld_pipe      <= {vld_pipe[0] && rd_legal, state == S_ISSUE};
      read_reg_num1 <= iss_legal ? iss_rs1 : 5'd0;
      read_reg_num2 <= iss_legal ? iss_rs2 : 5'd0;
      rd_rd         <= iss_legal ? iss_rd  : 5'd0;
      rd_legal      <= (state == S_ISSUE) && iss_legal;
      done_rd       <= rd_legal ? rd_rd : 5'd0;
      done_zero     <= rd_legal && zero_flag;
      if (vld_pipe[0] && rd_legal) retired_count <= retired_count + 1'b1;
    end
  end

  assign done_valid = vld_pipe[1];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  localparam int DEPTH = 4;
  localparam int CW    = 4;  // narrow counter so wrap-around is exercised

  logic          clock = 1'b0;
  logic          reset, instr_valid, run, zero_flag;
  logic [31:0]   instr;
  logic          instr_ready, regwrite, done_valid, done_zero, illegal, busy;
  logic [4:0]    read_reg_num1, read_reg_num2, write_reg, done_rd;
  logic [3:0]    alu_control;
  logic [CW-1:0] retired_count;

  alu_issue_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .run(run), .read_reg_num1(read_reg_num1),
    .read_reg_num2(read_reg_num2), .write_reg(write_reg), .alu_control(alu_control),
    .regwrite(regwrite), .zero_flag(zero_flag), .done_valid(done_valid),
    .done_rd(done_rd), .done_zero(done_zero), .illegal(illegal),
    .retired_count(retired_count), .busy(busy)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0011: return a ^ b;
      4'b0111: return {31'd0, $signed(a) < $signed(b)};
      default: return 32'd0;
    endcase
  endfunction

  // ---- datapath model: registers controls one cycle, reads unregistered
  logic [3:0]  dp_alu = 4'hF;
  logic [4:0]  dp_wr = 5'd0;
  logic        dp_we = 1'b0;
  logic        dp_load = 1'b0;
  logic [31:0] dp_rf [32];
  logic [31:0] ld_val [32];

  assign zero_flag = (alu_ref(dp_alu, dp_rf[read_reg_num1], dp_rf[read_reg_num2]) == 32'd0);

  always @(posedge clock) begin
    if (dp_load) begin
      for (int i = 0; i < 32; i++) dp_rf[i] <= ld_val[i];
    end else if (dp_we && dp_wr != 5'd0) begin
      dp_rf[dp_wr] <= alu_ref(dp_alu, dp_rf[read_reg_num1], dp_rf[read_reg_num2]);
    end
    dp_alu <= alu_control;
    dp_wr  <= write_reg;
    dp_we  <= regwrite;
  end

  // ---- reference model: FIFO contents, issue cycle of each word, architectural regs
  logic [31:0]   mdl [$];
  logic [31:0]   iss_at [int];
  logic [31:0]   ref_rf [32];
  logic [CW-1:0] exp_cnt = '0;
  int            cyc = 0;
  bit            last_push;
  int            iss_first, iss_last, iss_n, done_n, ill_n, rw_n;
  bit            zero_seen [$];

  function automatic void ref_decode(input logic [31:0] w, output bit legal, output logic [3:0] op);
    legal = 1'b0;
    op    = 4'hF;
    if (w[6:0] == 7'b0110011) begin
      legal = 1'b1;
      case ({w[31:25], w[14:12]})
        {7'h00, 3'd0}: op = 4'b0010;
        {7'h20, 3'd0}: op = 4'b0110;
        {7'h00, 3'd7}: op = 4'b0000;
        {7'h00, 3'd6}: op = 4'b0001;
        {7'h00, 3'd4}: op = 4'b0011;
        {7'h00, 3'd2}: op = 4'b0111;
        default:       legal = 1'b0;
      endcase
    end
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [9:0] f;
    case ($urandom_range(0, 5))
      0:       f = {7'h00, 3'd0};
      1:       f = {7'h20, 3'd0};
      2:       f = {7'h00, 3'd7};
      3:       f = {7'h00, 3'd6};
      4:       f = {7'h00, 3'd4};
      default: f = {7'h00, 3'd2};
    endcase
    return enc(f[9:3], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), f[2:0], 5'($urandom_range(0, 7)));
  endfunction

  // One clock: advance the model, then compare every DUT output against it.
  task automatic tick();
    bit do_pop, do_push, lg;
    logic [3:0]  op;
    logic [31:0] w, res;
    do_pop  = (mdl.size() != 0) && run;
    do_push = instr_valid && (mdl.size() < DEPTH);
    @(posedge clock);
    cyc++;
    if (do_pop)  iss_at[cyc] = mdl.pop_front();
    if (do_push) mdl.push_back(instr);
    last_push = do_push;
    #1;
    if (alu_control !== 4'hF) begin
      if (iss_n == 0) iss_first = cyc;
      iss_last = cyc;
      iss_n++;
    end
    if (illegal === 1'b1) ill_n++;
    if (regwrite === 1'b1) rw_n++;
    if (done_valid === 1'b1) begin done_n++; zero_seen.push_back(done_zero); end
    // issue stage
    if (iss_at.exists(cyc)) begin
      w = iss_at[cyc];
      ref_decode(w, lg, op);
      total++;
      if ({alu_control, regwrite, illegal} !== {op, lg && (w[11:7] != 5'd0), !lg}) begin
        bad++;
        $display("FAIL issue cyc=%0d w=%h got alu=%b rw=%b ill=%b exp alu=%b rw=%b ill=%b", cyc, w,
                 alu_control, regwrite, illegal, op, lg && (w[11:7] != 5'd0), !lg);
      end
      if (lg) begin
        total++;
        if (write_reg !== w[11:7]) begin bad++; $display("FAIL write_reg cyc=%0d got=%0d exp=%0d", cyc, write_reg, w[11:7]); end
      end
    end else begin
      total++;
      if ({alu_control, write_reg, regwrite, illegal} !== {4'hF, 5'd0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL bubble cyc=%0d got alu=%b wr=%0d rw=%b ill=%b exp alu=1111 wr=0 rw=0 ill=0", cyc,
                 alu_control, write_reg, regwrite, illegal);
      end
    end
    // read stage
    if (iss_at.exists(cyc - 1)) begin
      w = iss_at[cyc - 1];
      ref_decode(w, lg, op);
      if (lg) begin
        total++;
        if ({read_reg_num1, read_reg_num2} !== {w[19:15], w[24:20]}) begin
          bad++;
          $display("FAIL read_addr cyc=%0d got=%0d,%0d exp=%0d,%0d", cyc, read_reg_num1, read_reg_num2, w[19:15], w[24:20]);
        end
      end
    end else begin
      total++;
      if ({read_reg_num1, read_reg_num2} !== 10'd0) begin
        bad++;
        $display("FAIL read_idle cyc=%0d got=%0d,%0d exp=0,0", cyc, read_reg_num1, read_reg_num2);
      end
    end
    // done stage
    lg = 1'b0;
    if (iss_at.exists(cyc - 2)) begin
      w = iss_at[cyc - 2];
      ref_decode(w, lg, op);
    end
    total++;
    if (lg) begin
      res = alu_ref(op, ref_rf[w[19:15]], ref_rf[w[24:20]]);
      if (w[11:7] != 5'd0) ref_rf[w[11:7]] = res;
      exp_cnt++;
      if ({done_valid, done_rd, done_zero} !== {1'b1, w[11:7], res == 32'd0}) begin
        bad++;
        $display("FAIL done cyc=%0d got v=%b rd=%0d z=%b exp v=1 rd=%0d z=%b", cyc, done_valid, done_rd, done_zero,
                 w[11:7], res == 32'd0);
      end
    end else if (done_valid !== 1'b0) begin
      bad++;
      $display("FAIL done_spurious cyc=%0d got v=%b exp v=0", cyc, done_valid);
    end
    total++;
    if (retired_count !== exp_cnt) begin bad++; $display("FAIL retired cyc=%0d got=%0d exp=%0d", cyc, retired_count, exp_cnt); end
    total++;
    if (busy !== ((mdl.size() != 0) || iss_at.exists(cyc) || iss_at.exists(cyc - 1))) begin
      bad++;
      $display("FAIL busy cyc=%0d got=%b fifo=%0d", cyc, busy, mdl.size());
    end
    total++;
    if (instr_ready !== (mdl.size() < DEPTH)) begin
      bad++;
      $display("FAIL instr_ready cyc=%0d got=%b fifo=%0d", cyc, instr_ready, mdl.size());
    end
  endtask

  task automatic send(input logic [31:0] w);
    instr_valid = 1'b1;
    instr       = w;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (last_push) break;
    end
    instr_valid = 1'b0;
    if (!last_push) begin total++; bad++; $display("FAIL send_timeout w=%h not accepted", w); end
  endtask

  task automatic clr_mon();
    iss_n = 0; iss_first = 0; iss_last = 0; done_n = 0; ill_n = 0; rw_n = 0;
    zero_seen.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; run = 1'b0; instr_valid = 1'b1; instr = 32'h002081B3;
    for (int i = 0; i < 32; i++) begin
      ld_val[i] = (i == 0) ? 32'd0 : 32'($urandom_range(0, 3));
      ref_rf[i] = ld_val[i];
    end
    dp_load = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    dp_load = 1'b0;
    total++;
    if ({read_reg_num1, read_reg_num2, write_reg, alu_control, regwrite, done_valid, done_rd, done_zero,
         illegal, retired_count, busy, instr_ready} !== {5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b0, 5'd0, 1'b0,
         1'b0, {CW{1'b0}}, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_outputs got alu=%b wr=%0d rw=%b dv=%b ill=%b cnt=%0d busy=%b rdy=%b exp all 0, rdy=1",
               alu_control, write_reg, regwrite, done_valid, illegal, retired_count, busy, instr_ready);
    end
    reset = 1'b1;
    tick();
    instr_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL first_accept busy got=%b exp=1", busy); end
  endtask

  task automatic test_single_add();
    int start;
    clr_mon();
    start = cyc;
    run = 1'b1;
    repeat (4) tick();
    total++;
    if (iss_n != 1 || iss_first != start + 1 || done_n != 1) begin
      bad++;
      $display("FAIL add_timing got issues=%0d at=%0d dones=%0d exp 1 at %0d, 1", iss_n, iss_first, done_n, start + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [6];
    logic [CW-1:0] c0;
    clr_mon();
    c0 = exp_cnt;
    for (int i = 0; i < 6; i++) w[i] = rand_legal();
    run = 1'b0;
    for (int i = 0; i < 4; i++) send(w[i]);
    total++;
    if (instr_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", instr_ready); end
    run = 1'b1;
    send(w[4]);
    send(w[5]);
    repeat (6) tick();
    total++;
    if (iss_n != 6 || iss_last - iss_first != 5 || done_n != 6) begin
      bad++;
      $display("FAIL b2b got issues=%0d span=%0d dones=%0d exp 6,5,6", iss_n, iss_last - iss_first, done_n);
    end
    total++;
    if (retired_count !== CW'(c0 + 4'd6)) begin
      bad++;
      $display("FAIL b2b_count got=%0d exp=%0d", retired_count, CW'(c0 + 4'd6));
    end
  endtask

  task automatic test_illegal();
    logic [CW-1:0] c0;
    clr_mon();
    c0 = exp_cnt;
    run = 1'b1;
    send(32'h00000013);
    repeat (4) tick();
    total++;
    if (ill_n != 1 || rw_n != 0 || done_n != 0 || retired_count !== c0) begin
      bad++;
      $display("FAIL illegal got pulses=%0d rw=%0d dones=%0d cnt=%0d exp 1,0,0,%0d", ill_n, rw_n, done_n, retired_count, c0);
    end
  endtask

  task automatic test_sub_zero();
    for (int i = 0; i < 32; i++) ld_val[i] = ref_rf[i];
    ld_val[5] = 32'd7; ld_val[4] = 32'd3;
    ref_rf[5] = 32'd7; ref_rf[4] = 32'd3;
    dp_load = 1'b1;
    tick();
    dp_load = 1'b0;
    clr_mon();
    run = 1'b1;
    send(enc(7'h20, 5'd5, 5'd5, 3'd0, 5'd0));
    send(enc(7'h20, 5'd4, 5'd5, 3'd0, 5'd6));
    repeat (4) tick();
    total++;
    if (done_n != 2 || rw_n != 1 || zero_seen.size() != 2 || zero_seen[0] != 1'b1 || zero_seen[1] != 1'b0) begin
      bad++;
      $display("FAIL sub_zero got dones=%0d regwrites=%0d exp 2 dones (z=1 then 0), 1 regwrite", done_n, rw_n);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      run         = ($urandom_range(0, 9) < 8);
      instr_valid = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       instr = $urandom;
        1:       instr = enc(7'h20, 5'd1, 5'd2, 3'd7, 5'd3);
        default: instr = rand_legal();
      endcase
      tick();
    end
    instr_valid = 1'b0;
    run = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_run_and_reset();
    clr_mon();
    run = 1'b0;
    for (int i = 0; i < 4; i++) send(rand_legal());
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (4) tick();
    total++;
    if (iss_n != 1 || done_n != 1) begin
      bad++;
      $display("FAIL run_hold got issues=%0d dones=%0d exp 1,1", iss_n, done_n);
    end
    run = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    mdl.delete();
    iss_at.delete();
    exp_cnt = '0;
    #1;
    total++;
    if ({done_valid, busy, instr_ready, retired_count} !== {1'b0, 1'b0, 1'b1, {CW{1'b0}}}) begin
      bad++;
      $display("FAIL mid_reset got dv=%b busy=%b rdy=%b cnt=%0d exp 0,0,1,0", done_valid, busy, instr_ready, retired_count);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      total++;
      if (done_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold got dv=%b busy=%b exp 0,0", done_valid, busy);
      end
    end
    reset = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_illegal();
    test_sub_zero();
    test_random();
    test_run_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
